// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Result stream from the pixel scheduler to the colour/framebuffer writer.
// Valid/ready handshake carrying the pixel coordinate, its iteration count and an end-of-frame flag.
interface mandelbrot_pixel_scheduler_if #(
   parameter int COORD_WIDTH    = 12,
   parameter int MAX_ITER_WIDTH = 16
);
   logic                      valid;
   logic                      ready;
   logic [COORD_WIDTH-1:0]    x;
   logic [COORD_WIDTH-1:0]    y;
   logic [MAX_ITER_WIDTH-1:0] iter;
   logic                      last;

   modport master (output valid, x, y, iter, last, input ready);
   modport slave  (input valid, x, y, iter, last, output ready);
endinterface

// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster-scans a pixel window, launches one iteration-core run per pixel and streams
// (x, y, iter) results downstream. All outputs are registered.
module mandelbrot_pixel_scheduler #(
   parameter int  INTEGER_BITS    = 8,
   parameter int  FRACTIONAL_BITS = 24,
   parameter int  MAX_ITER_WIDTH  = 16,
   parameter int  COORD_WIDTH     = 12,
   localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         frame_start_i,
   input  logic [COORD_WIDTH-1:0]       width_i,
   input  logic [COORD_WIDTH-1:0]       height_i,
   input  logic signed [DATA_WIDTH-1:0] x_start_i,
   input  logic signed [DATA_WIDTH-1:0] y_start_i,
   input  logic signed [DATA_WIDTH-1:0] step_i,
   input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
   output logic                         core_start_o,
   output logic signed [DATA_WIDTH-1:0] core_x0_o,
   output logic signed [DATA_WIDTH-1:0] core_y0_o,
   output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
   input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
   input  logic                         core_done_i,
   mandelbrot_pixel_scheduler_if.master pix,
   output logic                         busy_o,
   output logic                         frame_done_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

   state_t                       state_q;
   logic [COORD_WIDTH-1:0]       width_q;
   logic [COORD_WIDTH-1:0]       height_q;
   logic signed [DATA_WIDTH-1:0] x_start_q;
   logic signed [DATA_WIDTH-1:0] step_q;
   logic [COORD_WIDTH-1:0]       px_q;
   logic [COORD_WIDTH-1:0]       py_q;
   logic signed [DATA_WIDTH-1:0] cx_q;
   logic signed [DATA_WIDTH-1:0] cy_q;

   logic                         last_col;
   logic                         last_pix;
   logic signed [DATA_WIDTH-1:0] cx_step;
   logic signed [DATA_WIDTH-1:0] cy_step;

   // Coordinate accumulators deliberately wrap modulo 2^DATA_WIDTH.
   function automatic logic signed [DATA_WIDTH-1:0] wrap_add(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return a + b;
   endfunction

   assign last_col = (px_q == width_q - COORD_WIDTH'(1));
   assign last_pix = last_col && (py_q == height_q - COORD_WIDTH'(1));
   assign cx_step  = wrap_add(cx_q, step_q);
   assign cy_step  = wrap_add(cy_q, step_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= S_IDLE;
         width_q         <= '0;
         height_q        <= '0;
         x_start_q       <= '0;
         step_q          <= '0;
         px_q            <= '0;
         py_q            <= '0;
         cx_q            <= '0;
         cy_q            <= '0;
         core_start_o    <= 1'b0;
         core_x0_o       <= '0;
         core_y0_o       <= '0;
         core_max_iter_o <= '0;
         pix.valid       <= 1'b0;
         pix.x           <= '0;
         pix.y           <= '0;
         pix.iter        <= '0;
         pix.last        <= 1'b0;
         busy_o          <= 1'b0;
         frame_done_o    <= 1'b0;
      end else begin
         core_start_o <= 1'b0;
         frame_done_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (frame_start_i) begin
                  width_q         <= width_i;
                  height_q        <= height_i;
                  x_start_q       <= x_start_i;
                  step_q          <= step_i;
                  core_max_iter_o <= max_iter_i;
                  px_q            <= '0;
                  py_q            <= '0;
                  cx_q            <= x_start_i;
                  cy_q            <= y_start_i;
                  if (width_i == '0 || height_i == '0) begin
                     frame_done_o <= 1'b1;
                  end else begin
                     state_q      <= S_ISSUE;
                     busy_o       <= 1'b1;
                     core_start_o <= 1'b1;
                     core_x0_o    <= x_start_i;
                     core_y0_o    <= y_start_i;
                  end
               end
            end
            S_ISSUE: state_q <= S_WAIT;
            S_WAIT: begin
               if (core_done_i) begin
                  pix.valid <= 1'b1;
                  pix.x     <= px_q;
                  pix.y     <= py_q;
                  pix.iter  <= core_iter_i;
                  pix.last  <= last_pix;
                  state_q   <= S_OUT;
               end
            end
            S_OUT: begin
               if (pix.ready) begin
                  pix.valid <= 1'b0;
                  pix.last  <= 1'b0;
                  if (last_pix) begin
                     state_q      <= S_IDLE;
                     busy_o       <= 1'b0;
                     frame_done_o <= 1'b1;
                  end else begin
                     state_q      <= S_ISSUE;
                     core_start_o <= 1'b1;
                     if (last_col) begin
                        px_q      <= '0;
                        py_q      <= py_q + COORD_WIDTH'(1);
                        cx_q      <= x_start_q;
                        cy_q      <= cy_step;
                        core_x0_o <= x_start_q;
                        core_y0_o <= cy_step;
                     end else begin
                        px_q      <= px_q + COORD_WIDTH'(1);
                        cx_q      <= cx_step;
                        core_x0_o <= cx_step;
                        core_y0_o <= cy_q;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
